// File: rtl/linear_iter.sv
// linear_iter: iterated linear diffusion over a 3-word block.
// A block is loaded in IDLE, transformed once per cycle in RUN for N
// steps, then presented in DONE until the consumer takes it.
// Optional build macro LINEAR_ITER_KEY_EN adds an in_key port and a key
// register K that is mixed into every step as T(S ^ K).
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both 1; the producer holds its valid and payload
// stable until that edge; ready may be asserted independently of valid.
module linear_iter #(
  parameter int W     = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3*W-1:0]   in_data,
  input  logic [CNT_W-1:0] in_iter,
`ifdef LINEAR_ITER_KEY_EN
  input  logic [3*W-1:0]   in_key,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3*W-1:0]   out_data,
  output logic [1:0]       dbg_state
);

  localparam int B = W / 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [3*W-1:0]     r_s;
  logic [CNT_W-1:0]   r_c;
  logic [3*W-1:0]     w_t;

  // One application of the linear map; word indices wrap modulo 3 and
  // every shift is a logical shift truncated to W bits.
  function automatic logic [3*W-1:0] t_fn(input logic [3*W-1:0] x);
    logic [3*W-1:0] y;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    y = '0;
    for (int i = 0; i < 3; i++) begin
      a = x[i*W +: W];
      b = x[((i + 1) % 3)*W +: W];
      c = x[((i + 2) % 3)*W +: W];
      y[i*W +: W] = a ^ (a >> (2*B)) ^ (a << (3*B)) ^ (a << (2*B)) ^ (a << B)
                  ^ (b << (2*B)) ^ (b >> (2*B)) ^ (b >> (3*B))
                  ^ (c << (2*B)) ^ (c << B) ^ (c >> B) ^ (c >> (2*B)) ^ (c >> (3*B));
    end
    return y;
  endfunction

`ifdef LINEAR_ITER_KEY_EN
  logic [3*W-1:0] r_k;
  assign w_t = t_fn(r_s ^ r_k);

  // Key register: captured together with the block at acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_k <= in_key;
    end
  end
`else
  assign w_t = t_fn(r_s);
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and handshake outputs; ready/valid depend only on state.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = (in_iter == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_c == CNT_W'(1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Block state and step counter: load on acceptance, step once per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s <= '0;
      r_c <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_s <= in_data;
            r_c <= in_iter;
          end
        end
        S_RUN: begin
          r_s <= w_t;
          r_c <= r_c - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data  = r_s;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_linear_iter.sv
// Testbench for linear_iter: directed and randomized blocks checked against
// a table-driven arithmetic model of the transform.
module tb_linear_iter;

  localparam int W     = 32;
  localparam int CNT_W = 4;
  localparam int B     = W / 4;
  localparam int BW    = 3 * W;
`ifdef LINEAR_ITER_KEY_EN
  localparam bit KEY_ON = 1'b1;
`else
  localparam bit KEY_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [BW-1:0]    in_data;
  logic [CNT_W-1:0] in_iter;
`ifdef LINEAR_ITER_KEY_EN
  logic [BW-1:0]    in_key;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [BW-1:0]    out_data;
  logic [1:0]       dbg_state;

  logic [BW-1:0]    exp_q[$];
  int               n_checks;
  int               n_fail;

  linear_iter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_iter   (in_iter),
`ifdef LINEAR_ITER_KEY_EN
    .in_key    (in_key),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper
  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference transform: each output word is the XOR of 13 terms, each term
  // a word (offset 0..2 from the output index) scaled by 2^(-shift*B),
  // using integer division for right shifts and multiply-mod-2^W for left.
  function automatic logic [BW-1:0] ref_t(input logic [BW-1:0] x);
    int off[13] = '{0, 0, 1, 1, 2, 1, 2, 2, 0, 2, 0, 2, 0};
    int sh[13]  = '{0, 2, -2, 2, -2, 3, -1, 1, -3, 2, -2, 3, -1};
    longint unsigned wd[3];
    longint unsigned modw;
    longint unsigned v;
    longint unsigned y;
    logic [BW-1:0]   r;
    modw = 64'd1 << W;
    r = '0;
    for (int i = 0; i < 3; i++) wd[i] = 64'(x[i*W +: W]);
    for (int i = 0; i < 3; i++) begin
      y = 0;
      for (int t = 0; t < 13; t++) begin
        v = wd[(i + off[t]) % 3];
        if (sh[t] > 0)      v = v / (64'd1 << (sh[t] * B));
        else if (sh[t] < 0) v = (v * (64'd1 << (-sh[t] * B))) % modw;
        y = y ^ v;
      end
      r[i*W +: W] = y[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] ref_block(input logic [BW-1:0] x, input int n,
                                              input logic [BW-1:0] key);
    logic [BW-1:0] s;
    logic [BW-1:0] k;
    k = KEY_ON ? key : '0;
    s = x;
    for (int i = 0; i < n; i++) s = ref_t(s ^ k);
    return s;
  endfunction

  function automatic logic [BW-1:0] rand_block();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Drive junk onto the input side while the DUT must ignore it.
  task automatic scramble();
    in_valid = 1'($urandom_range(0, 1));
    in_data  = rand_block();
    in_iter  = CNT_W'($urandom_range(0, 15));
`ifdef LINEAR_ITER_KEY_EN
    in_key   = rand_block();
`endif
  endtask

  // Driver + monitor for one block: offer, wait for the result, hold
  // out_ready low for 'hold' cycles, then complete the handshake.
  task automatic run_block(input string tag, input logic [BW-1:0] data, input int n,
                           input logic [BW-1:0] key, input int hold,
                           input logic [BW-1:0] exp_in);
    logic [BW-1:0] exp;
    int lat;
    exp_q.push_back(exp_in);
    @(negedge clk);
    check({tag, "_idle_ready"}, BW'(in_ready), BW'(1));
    in_valid = 1'b1;
    in_data  = data;
    in_iter  = CNT_W'(n);
`ifdef LINEAR_ITER_KEY_EN
    in_key   = key;
`else
    if (key != '0) ;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      check({tag, "_busy_ready"}, BW'(in_ready), BW'(0));
      scramble();
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, BW'(lat), BW'(n + 1));
    exp = exp_q.pop_front();
    check({tag, "_data"}, out_data, exp);
    for (int h = 0; h < hold; h++) begin
      scramble();
      @(negedge clk);
      check({tag, "_hold_valid"}, BW'(out_valid), BW'(1));
      check({tag, "_hold_data"}, out_data, exp);
      check({tag, "_hold_ready"}, BW'(in_ready), BW'(0));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_after_valid"}, BW'(out_valid), BW'(0));
    check({tag, "_after_ready"}, BW'(in_ready), BW'(1));
  endtask

  logic [BW-1:0] x;
  logic [BW-1:0] k;
  int            n;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_iter   = '0;
    out_ready = 1'b0;
`ifdef LINEAR_ITER_KEY_EN
    in_key    = '0;
`endif
    // Reset block
    repeat (3) @(negedge clk);
    check("rst_in_ready", BW'(in_ready), BW'(1));
    check("rst_out_valid", BW'(out_valid), BW'(0));
    check("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single step from a unit vector
    run_block("unit_n1", {32'h0, 32'h0, 32'h1}, 1, '0, 0,
              {32'h00010000, 32'h00010100, 32'h01010101});
    // Maximum count on a zero block
    run_block("zero_n15", '0, 15, '0, 1, '0);
    // Random block, two steps
    x = rand_block();
    run_block("rand_n2", x, 2, '0, 0, ref_block(x, 2, '0));
    // Zero iterations returns the input
    run_block("pass_n0", 96'h123456789ABCDEF0FEDCBA98, 0, '0, 0,
              96'h123456789ABCDEF0FEDCBA98);
    // Long back-pressure in DONE
    x = rand_block();
    run_block("hold10", x, 3, '0, 10, ref_block(x, 3, '0));

    // Reset in the middle of a RUN: block aborted, reset-cycle offer ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rand_block();
    in_iter  = CNT_W'(8);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_iter  = '0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("abort_in_ready", BW'(in_ready), BW'(1));
    check("abort_out_valid", BW'(out_valid), BW'(0));
    check("abort_out_data", out_data, '0);
    check("abort_state", BW'(dbg_state), BW'(0));
    @(negedge clk);
    check("abort_no_accept_valid", BW'(out_valid), BW'(0));
    check("abort_no_accept_ready", BW'(in_ready), BW'(1));
    x = rand_block();
    run_block("post_abort", x, 5, '0, 0, ref_block(x, 5, '0));

`ifdef LINEAR_ITER_KEY_EN
    // Key only: T(0 ^ all-ones)
    run_block("key_ones", '0, 1, '1, 0, ref_t('1));
`endif

    // Randomized blocks
    for (int r = 0; r < 12; r++) begin
      x = rand_block();
      k = rand_block();
      n = $urandom_range(0, 15);
      run_block("rand", x, n, k, $urandom_range(0, 3), ref_block(x, n, k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
